// File: rtl/alu_serial_host_if.sv
// Serial pin side (sdi/sdo plus status) and ALU operand/result side of alu_serial_host.
// slave is the host block's view; master is the view of whatever drives the pins and models the ALU.
interface alu_serial_host_if #(
    parameter int DATA_W = 4,
    parameter int FN_W   = 2
);
    logic              sdi;
    logic              sdi_valid;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [FN_W-1:0]   f;
    logic [DATA_W-1:0] xy;
    logic              sdo;
    logic              sdo_valid;
    logic              busy;
    logic              overrun;
    logic              perr;

    modport slave (
        input  sdi, sdi_valid, xy,
        output x, y, f, sdo, sdo_valid, busy, overrun, perr
    );

    modport master (
        output sdi, sdi_valid, xy,
        input  x, y, f, sdo, sdo_valid, busy, overrun, perr
    );
endinterface

// File: rtl/alu_serial_host.sv
// Bit-serial front end for the ALU: deserialises X/Y/F, waits for XY to settle, then serialises XY back out.
// Defining PARITY_EN appends an even-parity bit to each request frame.
module alu_serial_host #(
    parameter int DATA_W  = 4,
    parameter int FN_W    = 2,
    parameter int ALU_LAT = 0
) (
    input logic              clk,
    input logic              rst,
    alu_serial_host_if.slave bus
);
`ifdef PARITY_EN
    localparam int FRAME_W = 2 * DATA_W + FN_W + 1;
`else
    localparam int FRAME_W = 2 * DATA_W + FN_W;
`endif
    localparam int CNT_MAX0 = (FRAME_W - 1 > ALU_LAT) ? FRAME_W - 1 : ALU_LAT;
    localparam int CNT_MAX  = (CNT_MAX0 > DATA_W - 1) ? CNT_MAX0 : DATA_W - 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_TX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-2:0] frame_q, frame_d;
    logic [FRAME_W-1:0] frame_shift;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  y_q, y_d;
    logic [FN_W-1:0]    f_q, f_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               overrun_q, overrun_d;
`ifdef PARITY_EN
    logic               perr_q, perr_d;
`endif

    // NOTE: every state register is written with <= so all of them update together from the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RX;
            cnt_q     <= '0;
            frame_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            f_q       <= '0;
            res_q     <= '0;
            overrun_q <= 1'b0;
`ifdef PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            x_q       <= x_d;
            y_q       <= y_d;
            f_q       <= f_d;
            res_q     <= res_d;
            overrun_q <= overrun_d;
`ifdef PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // NOTE: every variable gets a hold/default value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        x_d         = x_q;
        y_d         = y_q;
        f_d         = f_q;
        res_d       = res_q;
        overrun_d   = 1'b0;
`ifdef PARITY_EN
        perr_d      = 1'b0;
`endif
        // Bits arrive LSB first, so the newest bit enters at the top; on the last bit this is the whole frame.
        frame_shift = {bus.sdi, frame_q};

        unique case (state_q)
            ST_RX: begin
                if (bus.sdi_valid) begin
                    frame_d = frame_shift[FRAME_W-1:1];
                    if (cnt_q == RX_LAST) begin
                        cnt_d = '0;
`ifdef PARITY_EN
                        if (^frame_shift) begin
                            perr_d = 1'b1;
                        end else begin
                            x_d     = frame_shift[DATA_W-1:0];
                            y_d     = frame_shift[2*DATA_W-1:DATA_W];
                            f_d     = frame_shift[2*DATA_W+FN_W-1:2*DATA_W];
                            state_d = ST_EXEC;
                        end
`else
                        x_d     = frame_shift[DATA_W-1:0];
                        y_d     = frame_shift[2*DATA_W-1:DATA_W];
                        f_d     = frame_shift[2*DATA_W+FN_W-1:2*DATA_W];
                        state_d = ST_EXEC;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EXEC: begin
                overrun_d = bus.sdi_valid;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    res_d   = bus.xy;
                    state_d = ST_TX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TX: begin
                overrun_d = bus.sdi_valid;
                res_d     = {1'b0, res_q[DATA_W-1:1]};
                if (cnt_q == TX_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RX;
        endcase
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.f         = f_q;
    assign bus.sdo_valid = (state_q == ST_TX);
    assign bus.sdo       = (state_q == ST_TX) & res_q[0];
    assign bus.busy      = (state_q != ST_RX);
    assign bus.overrun   = overrun_q;
`ifdef PARITY_EN
    assign bus.perr      = perr_q;
`else
    assign bus.perr      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial_host.sv
// Directed bench for alu_serial_host: table-driven frames plus hand-written gap, overrun, reset, parity and latency cases.
// A second instance with ALU_LAT=3 has its xy driven directly by the bench.
module tb_alu_serial_host;
`ifdef PARITY_EN
    localparam int FRAME_W = 11;
`else
    localparam int FRAME_W = 10;
`endif

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] f;
        logic [3:0] exp_xy;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       sdi_r = 1'b0;
    logic       vld_r = 1'b0;
    logic       tgt   = 1'b0;
    logic [3:0] xy_l  = 4'h0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Reference ALU: 0 add, 1 subtract, 2 shift X left, 3 AND (all mod 16).
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] fn);
        case (fn)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return {a[2:0], 1'b0};
            default: return a & b;
        endcase
    endfunction

    alu_serial_host_if #(.DATA_W(4), .FN_W(2)) bus_m ();
    alu_serial_host_if #(.DATA_W(4), .FN_W(2)) bus_l ();

    assign bus_m.sdi       = sdi_r;
    assign bus_m.sdi_valid = vld_r & ~tgt;
    assign bus_m.xy        = alu_model(bus_m.x, bus_m.y, bus_m.f);
    assign bus_l.sdi       = sdi_r;
    assign bus_l.sdi_valid = vld_r & tgt;
    assign bus_l.xy        = xy_l;

    alu_serial_host #(.DATA_W(4), .FN_W(2), .ALU_LAT(0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    alu_serial_host #(.DATA_W(4), .FN_W(2), .ALU_LAT(3)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [3:0] xv, input logic [3:0] yv, input logic [1:0] fv);
        logic [FRAME_W-1:0] fr;
        fr      = '0;
        fr[9:0] = {fv, yv, xv};
`ifdef PARITY_EN
        fr[10]  = ^{fv, yv, xv};
`endif
        return fr;
    endfunction

    // Called just after a rising edge; returns 1 ns into cycle N+1.
    task automatic send_frame(input logic [FRAME_W-1:0] fr, input int gap_a, input int gap_b);
        for (int i = 0; i < FRAME_W; i++) begin
            sdi_r = fr[i];
            vld_r = 1'b1;
            @(posedge clk); #1;
            vld_r = 1'b0;
            if (i == gap_a || i == gap_b) begin
                repeat (3) begin
                    @(posedge clk); #1;
                end
            end
        end
        sdi_r = 1'b0;
    endtask

    task automatic run_frame(input logic [3:0] xv, input logic [3:0] yv, input logic [1:0] fv,
                             input logic [3:0] expv, input int gap_a, input int gap_b, input bit ovr);
        send_frame(mk_frame(xv, yv, fv), gap_a, gap_b);
        check("x_load", bus_m.x, xv);
        check("y_load", bus_m.y, yv);
        check("f_load", bus_m.f, fv);
        check("busy_exec", bus_m.busy, 1);
        check("sdo_valid_exec", bus_m.sdo_valid, 0);
        check("overrun_idle", bus_m.overrun, 0);
        check("perr_idle", bus_m.perr, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vld_r = 1'b0;
            sdi_r = 1'b0;
            check("sdo_valid_tx", bus_m.sdo_valid, 1);
            check("sdo_bit", bus_m.sdo, expv[i]);
            if (ovr && i == 2) check("overrun_pulse", bus_m.overrun, 1);
            if (ovr && i == 3) check("overrun_clear", bus_m.overrun, 0);
            if (ovr && i == 1) begin
                sdi_r = 1'b1;
                vld_r = 1'b1;
            end
        end
        @(posedge clk); #1;
        check("sdo_valid_done", bus_m.sdo_valid, 0);
        check("busy_done", bus_m.busy, 0);
        check("x_hold", bus_m.x, xv);
    endtask

    vec_t       vecs[7];
    logic [3:0] lat_xy[9];
    logic [3:0] lat_exp;
    logic [FRAME_W-1:0] fr;

    initial begin
        vecs[0] = '{x: 4'd5,  y: 4'd3, f: 2'd0, exp_xy: 4'd8};
        vecs[1] = '{x: 4'd3,  y: 4'd5, f: 2'd1, exp_xy: 4'd14};
        vecs[2] = '{x: 4'd9,  y: 4'd0, f: 2'd2, exp_xy: 4'd2};
        vecs[3] = '{x: 4'd9,  y: 4'd0, f: 2'd3, exp_xy: 4'd0};
        vecs[4] = '{x: 4'd15, y: 4'd1, f: 2'd0, exp_xy: 4'd0};
        vecs[5] = '{x: 4'd12, y: 4'd3, f: 2'd1, exp_xy: 4'd9};
        vecs[6] = '{x: 4'd7,  y: 4'd6, f: 2'd3, exp_xy: 4'd6};
        lat_xy  = '{4'h0, 4'h1, 4'h3, 4'h5, 4'hA, 4'hF, 4'h6, 4'h9, 4'hC};
        lat_exp = 4'hA;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", bus_m.x, 0);
        check("rst_y", bus_m.y, 0);
        check("rst_f", bus_m.f, 0);
        check("rst_sdo", bus_m.sdo, 0);
        check("rst_sdo_valid", bus_m.sdo_valid, 0);
        check("rst_busy", bus_m.busy, 0);
        check("rst_overrun", bus_m.overrun, 0);
        check("rst_perr", bus_m.perr, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].exp_xy, -1, -1, 1'b0);

        // Idle gaps after bits 2 and 7.
        run_frame(4'd5, 4'd3, 2'd0, 4'd8, 2, 7, 1'b0);

        // Overrun in N+3, then a clean frame.
        run_frame(4'd3, 4'd5, 2'd1, 4'd14, -1, -1, 1'b1);
        run_frame(4'd9, 4'd0, 2'd2, 4'd2, -1, -1, 1'b0);

        // Reset after six frame bits discards the partial frame.
        fr = mk_frame(4'd15, 4'd15, 2'd3);
        for (int i = 0; i < 6; i++) begin
            sdi_r = fr[i];
            vld_r = 1'b1;
            @(posedge clk); #1;
        end
        vld_r = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        check("midrx_rst_x", bus_m.x, 0);
        check("midrx_rst_busy", bus_m.busy, 0);
        run_frame(4'd1, 4'd1, 2'd0, 4'd2, -1, -1, 1'b0);

        // Reset during TX drops the rest of the result.
        send_frame(mk_frame(4'd5, 4'd3, 2'd0), -1, -1);
        @(posedge clk); #1;
        check("midtx_in_tx", bus_m.sdo_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("midtx_no_sdo", bus_m.sdo_valid, 0);
            check("midtx_not_busy", bus_m.busy, 0);
            @(posedge clk); #1;
        end
        run_frame(4'd12, 4'd3, 2'd1, 4'd9, -1, -1, 1'b0);

`ifdef PARITY_EN
        // Flipped parity: pulse perr, keep operands, no result.
        fr = mk_frame(4'd6, 4'd2, 2'd0);
        fr[FRAME_W-1] = ~fr[FRAME_W-1];
        send_frame(fr, -1, -1);
        check("perr_pulse", bus_m.perr, 1);
        check("perr_no_busy", bus_m.busy, 0);
        check("perr_x_kept", bus_m.x, 12);
        check("perr_y_kept", bus_m.y, 3);
        check("perr_f_kept", bus_m.f, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("perr_no_sdo", bus_m.sdo_valid, 0);
            if (i == 0) check("perr_clear", bus_m.perr, 0);
        end
        run_frame(4'd6, 4'd2, 2'd0, 4'd8, -1, -1, 1'b0);
`endif

        // ALU_LAT=3: only the xy present in N+4 is captured; first sdo_valid in N+5.
        tgt = 1'b1;
        send_frame(mk_frame(4'd2, 4'd2, 2'd0), -1, -1);
        check("lat_x_load", bus_l.x, 2);
        for (int c = 1; c <= 8; c++) begin
            xy_l = lat_xy[c];
            check("lat_busy", bus_l.busy, 1);
            check("lat_sdo_valid", bus_l.sdo_valid, (c >= 5) ? 1 : 0);
            if (c >= 5) check("lat_sdo_bit", bus_l.sdo, lat_exp[c-5]);
            @(posedge clk); #1;
        end
        check("lat_sdo_valid_done", bus_l.sdo_valid, 0);
        check("lat_busy_done", bus_l.busy, 0);
        tgt = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
